// File: rtl/cache_fill_arbiter_if.sv
// Bundle between the fill arbiter, its two cache clients and the SDRAM burst-read port.
// The master modport is the arbiter's view; slave is the clients/controller view.
interface cache_fill_arbiter_if;
  logic        c0_req;
  logic [24:0] c0_addr;
  logic        c0_fill;
  logic        c1_req;
  logic [24:0] c1_addr;
  logic        c1_fill;
  logic [15:0] fill_data;
  logic        sd_req;
  logic [24:0] sd_addr;
  logic        sd_ack;
  logic        sd_dvalid;
  logic [15:0] sd_data;
  logic        grant;
  logic        busy;
  logic        err;

  modport master (
    input  c0_req, c0_addr, c1_req, c1_addr, sd_ack, sd_dvalid, sd_data,
    output c0_fill, c1_fill, fill_data, sd_req, sd_addr, grant, busy, err
  );

  modport slave (
    output c0_req, c0_addr, c1_req, c1_addr, sd_ack, sd_dvalid, sd_data,
    input  c0_fill, c1_fill, fill_data, sd_req, sd_addr, grant, busy, err
  );
endinterface

// File: rtl/cache_fill_arbiter.sv
// Round-robin arbiter sharing one SDRAM burst-read port between two cache fill clients,
// with a request/first-word watchdog and a sticky error flag for lost or short bursts.
module cache_fill_arbiter #(
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  cache_fill_arbiter_if.master bus
);
  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAITDATA, STREAM} state_t;

  state_t        state_reg;
  logic          sd_req_reg;
  logic [24:0]   sd_addr_reg;
  logic [1:0]    fill_reg;
  logic [15:0]   fill_data_reg;
  logic          grant_reg;
  logic          busy_reg;
  logic          err_reg;
  logic          last_reg;
  logic [CW-1:0] cnt_reg;
  logic [WW-1:0] wdog_reg;

  logic pick_c1;
  logic any_req;

  // On a tie the client that was not served last wins.
  always_comb begin
    any_req = bus.c0_req | bus.c1_req;
    pick_c1 = bus.c1_req & (~bus.c0_req | ~last_reg);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      sd_req_reg    <= 1'b0;
      sd_addr_reg   <= '0;
      fill_reg      <= '0;
      fill_data_reg <= '0;
      grant_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
      last_reg      <= 1'b1;
      cnt_reg       <= '0;
      wdog_reg      <= '0;
    end else begin
      fill_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            grant_reg   <= pick_c1;
            last_reg    <= pick_c1;
            sd_addr_reg <= pick_c1 ? bus.c1_addr : bus.c0_addr;
            sd_req_reg  <= 1'b1;
            busy_reg    <= 1'b1;
            wdog_reg    <= '0;
            state_reg   <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.sd_ack) begin
            sd_req_reg <= 1'b0;
            if (bus.sd_dvalid) begin
              fill_data_reg       <= bus.sd_data;
              fill_reg[grant_reg] <= 1'b1;
              cnt_reg             <= CW'(1);
              state_reg           <= STREAM;
            end else begin
              state_reg <= WAITDATA;
            end
          end else if (wdog_reg == WD_LAST) begin
            err_reg    <= 1'b1;
            sd_req_reg <= 1'b0;
            busy_reg   <= 1'b0;
            state_reg  <= IDLE;
          end else begin
            wdog_reg <= wdog_reg + WW'(1);
          end
        end
        WAITDATA: begin
          if (bus.sd_dvalid) begin
            fill_data_reg       <= bus.sd_data;
            fill_reg[grant_reg] <= 1'b1;
            cnt_reg             <= CW'(1);
            state_reg           <= STREAM;
          end else if (wdog_reg == WD_LAST) begin
            err_reg   <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            wdog_reg <= wdog_reg + WW'(1);
          end
        end
        STREAM: begin
          if (bus.sd_dvalid) begin
            fill_data_reg <= bus.sd_data;
            cnt_reg       <= cnt_reg + CW'(1);
            if (cnt_reg + CW'(1) == CNT_LAST) begin
              busy_reg  <= 1'b0;
              state_reg <= IDLE;
            end
          end else begin
            // Short burst: the words already delivered stay in the cache line.
            err_reg   <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.sd_req    = sd_req_reg;
  assign bus.sd_addr   = sd_addr_reg;
  assign bus.c0_fill   = fill_reg[0];
  assign bus.c1_fill   = fill_reg[1];
  assign bus.fill_data = fill_data_reg;
  assign bus.grant     = grant_reg;
  assign bus.busy      = busy_reg;
  assign bus.err       = err_reg;
endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter: a queue of expected fill words and an error-onset
// cycle are built from the burst rules and compared against the outputs every cycle.
module tb_cache_fill_arbiter;
  localparam int BL  = 8;
  localparam int TO  = 15;
  localparam int BIG = 32'h7fff_ffff;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  cache_fill_arbiter_if ifc();

  cache_fill_arbiter #(.BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(ifc)
  );

  typedef struct {
    int          cyc;
    logic        f0;
    logic        f1;
    logic [15:0] d;
  } fill_t;

  fill_t fq[$];
  fill_t head;
  int    cyc = 0;
  int    n_checks = 0;
  int    n_errors = 0;
  int    err_on = BIG;
  bit    chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the expected fill stream and the error onset.
  always @(negedge clk) begin
    if (chk_en) begin
      if (fq.size() > 0 && fq[0].cyc < cyc) begin
        head = fq.pop_front();
        chk("fill_missed_cycle", cyc, head.cyc);
      end
      if (fq.size() > 0 && fq[0].cyc == cyc) begin
        head = fq.pop_front();
        chk("c0_fill", ifc.c0_fill, head.f0);
        chk("c1_fill", ifc.c1_fill, head.f1);
        chk("fill_data", ifc.fill_data, head.d);
      end else begin
        chk("fill_idle", {ifc.c1_fill, ifc.c0_fill}, 0);
      end
      chk("fill_exclusive", ifc.c0_fill & ifc.c1_fill, 0);
      chk("err", ifc.err, (cyc >= err_on));
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sd_req"}, ifc.sd_req, 0);
    chk({tag, "_sd_addr"}, ifc.sd_addr, 0);
    chk({tag, "_c0_fill"}, ifc.c0_fill, 0);
    chk({tag, "_c1_fill"}, ifc.c1_fill, 0);
    chk({tag, "_fill_data"}, ifc.fill_data, 0);
    chk({tag, "_grant"}, ifc.grant, 0);
    chk({tag, "_busy"}, ifc.busy, 0);
    chk({tag, "_err"}, ifc.err, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    err_on = BIG;
    fq.delete();
    chk_en = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk_reset_vals("reset");
    $display("reset applied at cycle %0d", cyc);
  endtask

  // Serves one burst as the SDRAM controller; called one step after a clock edge.
  task automatic do_burst(input int cl, input logic [24:0] addr, input int ack_dly,
                          input int nwords, input logic [15:0] base, input bit ack_data,
                          input logic [1:0] drop, input int rst_word, input int exp_wait);
    int    w = 0;
    int    first_i = 0;
    bit    in_rst = 1'b0;
    fill_t e;
    while (!ifc.sd_req && w < 64) begin
      @(posedge clk); #1;
      w++;
    end
    chk("sd_req_seen", ifc.sd_req, 1);
    if (!ifc.sd_req) return;
    chk("req_latency", w, exp_wait);
    chk("sd_addr", ifc.sd_addr, addr);
    chk("grant", ifc.grant, cl);
    chk("busy", ifc.busy, 1);
    repeat (ack_dly) begin
      @(posedge clk); #1;
      chk("sd_req_hold", ifc.sd_req, 1);
      chk("sd_addr_hold", ifc.sd_addr, addr);
    end
    ifc.sd_ack = 1'b1;
    if (ack_data) begin
      ifc.sd_dvalid = 1'b1;
      ifc.sd_data   = base;
      e.cyc = cyc + 1; e.f0 = (cl == 0); e.f1 = (cl == 1); e.d = base;
      fq.push_back(e);
      first_i = 1;
    end
    @(posedge clk); #1;
    ifc.sd_ack = 1'b0;
    chk("sd_req_after_ack", ifc.sd_req, 0);
    for (int i = first_i; i < nwords; i++) begin
      if (i == 1) begin
        if (drop[0]) ifc.c0_req = 1'b0;
        if (drop[1]) ifc.c1_req = 1'b0;
      end
      if (i == rst_word) begin
        reset_n    = 1'b0;
        ifc.c0_req = 1'b0;
        ifc.c1_req = 1'b0;
        in_rst     = 1'b1;
      end
      ifc.sd_dvalid = 1'b1;
      ifc.sd_data   = base + 16'(i);
      if (!in_rst) begin
        e.cyc = cyc + 1; e.f0 = (i == 0) && (cl == 0); e.f1 = (i == 0) && (cl == 1);
        e.d = base + 16'(i);
        fq.push_back(e);
      end
      @(posedge clk); #1;
      if (!reset_n) begin
        reset_n = 1'b1;
        err_on  = BIG;
        chk_reset_vals("midreset");
      end
    end
    ifc.sd_dvalid = 1'b0;
    if (nwords < BL) begin
      if (err_on == BIG) err_on = cyc + 1;
      @(posedge clk); #1;
      chk("short_err", ifc.err, 1);
    end
    chk("busy_end", ifc.busy, 0);
    $display("burst client=%0d addr=0x%07h ack_wait=%0d words=%0d ack_data=%0d reset_word=%0d",
             cl, addr, ack_dly, nwords, ack_data, rst_word);
  endtask

  initial begin
    int n;
    int w;
    reset_n       = 1'b0;
    ifc.c0_req    = 1'b0;
    ifc.c0_addr   = '0;
    ifc.c1_req    = 1'b0;
    ifc.c1_addr   = '0;
    ifc.sd_ack    = 1'b0;
    ifc.sd_dvalid = 1'b0;
    ifc.sd_data   = '0;
    do_reset();

    // Single request with a three-cycle acknowledge delay.
    ifc.c0_addr = 25'h0123456;
    ifc.c0_req  = 1'b1;
    do_burst(0, 25'h0123456, 3, 8, 16'hA000, 1'b0, 2'b01, -1, 1);

    // Both requests held: after reset client 0 wins, then strict alternation.
    do_reset();
    ifc.c0_addr = 25'h0000100;
    ifc.c1_addr = 25'h1ABCDE0;
    ifc.c0_req  = 1'b1;
    ifc.c1_req  = 1'b1;
    do_burst(0, 25'h0000100, 1, 8, 16'h1000, 1'b0, 2'b00, -1, 1);
    do_burst(1, 25'h1ABCDE0, 2, 8, 16'h2000, 1'b0, 2'b00, -1, 1);
    do_burst(0, 25'h0000100, 0, 8, 16'h3000, 1'b0, 2'b00, -1, 1);
    do_burst(1, 25'h1ABCDE0, 1, 8, 16'h4000, 1'b0, 2'b11, -1, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("quiet_sd_req", ifc.sd_req, 0);
    chk("quiet_busy", ifc.busy, 0);

    // Acknowledge and first data word on the same cycle.
    ifc.c1_addr = 25'h0FEDCBA;
    ifc.c1_req  = 1'b1;
    do_burst(1, 25'h0FEDCBA, 2, 8, 16'h5A00, 1'b1, 2'b10, -1, 1);

    // Reset while word 3 is on the bus; the rest of the burst must be ignored.
    ifc.c0_addr = 25'h0000040;
    ifc.c0_req  = 1'b1;
    do_burst(0, 25'h0000040, 1, 8, 16'hB000, 1'b0, 2'b00, 3, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_idle", ifc.busy, 0);

    // Watchdog: request never acknowledged.
    ifc.c1_addr = 25'h1555555;
    ifc.c1_req  = 1'b1;
    w = 0;
    while (!ifc.sd_req && w < 64) begin
      @(posedge clk); #1;
      w++;
    end
    chk("to_req_latency", w, 1);
    chk("to_sd_addr", ifc.sd_addr, 25'h1555555);
    chk("to_grant", ifc.grant, 1);
    err_on = cyc + TO;
    n = 1;
    while (ifc.sd_req && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    chk("to_drop_cycle", n, 16);
    chk("to_err", ifc.err, 1);
    chk("to_busy", ifc.busy, 0);
    $display("timeout client=1 sd_req dropped at cycle %0d of the request", n);
    do_burst(1, 25'h1555555, 1, 8, 16'hC000, 1'b0, 2'b10, -1, 1);

    // Short burst: only five words arrive.
    do_reset();
    ifc.c0_addr = 25'h0002220;
    ifc.c0_req  = 1'b1;
    do_burst(0, 25'h0002220, 1, 5, 16'hD000, 1'b0, 2'b01, -1, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("short_no_regrant", ifc.sd_req, 0);
    chk("short_err_sticky", ifc.err, 1);
    chk("fill_queue_drained", fq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
